// File: rtl/rv32_pkg.sv
// Shared RV32 core constants: data width, register file geometry and writeback source indices.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap-around.
// The pointer moves one past the winner; with no grant it holds.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx;
  int unsigned     idx_wide;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    idx      = '0;
    idx_wide = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx_wide = 32'(ptr_q) + off;
      if (idx_wide >= N) idx_wide = idx_wide - N;
      idx = IdxW'(idx_wide);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (idx_wide == N - 1) ? '0 : IdxW'(idx_wide + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between writeback sources and tracks
// destinations with an outstanding write for RAW stall detection in decode.
module wb_port_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = rv32_pkg::XLEN
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  input  logic [NUM_REQ*rv32_pkg::REG_ADDR_W-1:0]  req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0]                  req_data_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  output logic                                     rf_we_o,
  output logic [rv32_pkg::REG_ADDR_W-1:0]          rf_rd_o,
  output logic [XLEN-1:0]                          rf_data_o,
  input  logic                                     issue_valid_i,
  input  logic [rv32_pkg::REG_ADDR_W-1:0]          issue_rd_i,
  input  logic [rv32_pkg::REG_ADDR_W-1:0]          rs1_i,
  input  logic [rv32_pkg::REG_ADDR_W-1:0]          rs2_i,
  output logic                                     rs1_pending_o,
  output logic                                     rs2_pending_o
);

  localparam int unsigned RegW  = rv32_pkg::REG_ADDR_W;
  localparam int unsigned NRegs = rv32_pkg::NUM_REGS;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [RegW-1:0]    sel_rd;
  logic [XLEN-1:0]    sel_data;

  logic               rf_we_q, rf_we_d;
  logic [RegW-1:0]    rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]    rf_data_q, rf_data_d;
  logic [NRegs-1:0]   pending_q, pending_d;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_valid_i),
    .gnt_o  (gnt)
  );

  // Grants are suppressed combinationally while reset is held.
  assign req_ready_o = gnt & {NUM_REQ{rst_ni}};
  assign gnt_valid   = |gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd_i[i*RegW +: RegW];
        sel_data = req_data_i[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (gnt_valid) begin
      rf_we_d   = (sel_rd != '0);
      rf_rd_d   = sel_rd;
      rf_data_d = sel_data;
    end
  end

  // Clear first so a same-cycle issue to the committing register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_rd_q] = 1'b0;
    if (issue_valid_i && (issue_rd_i != '0)) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
    end
  end

  assign rf_we_o       = rf_we_q;
  assign rf_rd_o       = rf_rd_q;
  assign rf_data_o     = rf_data_q;
  assign rs1_pending_o = pending_q[rs1_i];
  assign rs2_pending_o = pending_q[rs2_i];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes are queued when stimulus
// is driven and compared against the register file port one cycle later.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [4:0]  rd_v [3];
  logic [31:0] data_v [3];
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_pending, rs2_pending;

  assign req_rd   = {rd_v[2], rd_v[1], rd_v[0]};
  assign req_data = {data_v[2], data_v[1], data_v[0]};

  wb_port_arbiter #(
    .NUM_REQ (3),
    .XLEN    (32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_rd_i      (req_rd),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .rf_we_o       (rf_we),
    .rf_rd_o       (rf_rd),
    .rf_data_o     (rf_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rs1_pending_o (rs1_pending),
    .rs2_pending_o (rs2_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_ptr;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [2:0]  g;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Rotate the valid vector so the pointer lands at bit 0, take the lowest set bit.
  function automatic logic [2:0] model_grant(input logic [2:0] v, input int p);
    logic [5:0] dbl;
    logic [2:0] rot;
    dbl = {v, v} >> p;
    rot = dbl[2:0];
    for (int k = 0; k < 3; k++) begin
      if (rot[k]) return 3'(1 << ((k + p) % 3));
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = '0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  // Entered just after a negedge with inputs already driven; leaves at the next negedge.
  task automatic cycle(output logic [2:0] gnt);
    wr_t e;
    #1;
    gnt = model_grant(req_valid, m_ptr);
    check_eq("req_ready", 32'(req_ready), 32'(gnt));
    check_eq("rs1_pending", 32'(rs1_pending), 32'(m_pend[rs1]));
    check_eq("rs2_pending", 32'(rs2_pending), 32'(m_pend[rs2]));
    e.we   = 1'b0;
    e.rd   = m_rd;
    e.data = m_data;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) begin
        e.we   = (rd_v[i] != 5'd0);
        e.rd   = rd_v[i];
        e.data = data_v[i];
        m_ptr  = (i + 1) % 3;
      end
    end
    if (m_we) m_pend[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    m_we   = e.we;
    m_rd   = e.rd;
    m_data = e.data;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("rf_we", 32'(rf_we), 32'(e.we));
      check_eq("rf_rd", 32'(rf_rd), 32'(e.rd));
      check_eq("rf_data", rf_data, e.data);
    end
  endtask

  task automatic drop_granted(input logic [2:0] gnt);
    req_valid = req_valid & ~gnt;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rf_rd", 32'(rf_rd), 32'd0);
    check_eq("rst_rf_data", rf_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n       = 1'b1;
    req_valid   = 3'b111;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = 5'd1;
    rs2         = 5'd2;
    for (int i = 0; i < 3; i++) begin
      rd_v[i]   = 5'(i + 1);
      data_v[i] = 32'h100 + 32'(i);
    end
    model_reset();
    @(negedge clk);
    hold_reset();
    req_valid = 3'b000;
    repeat (2) cycle(g);

    // Single ALU write
    rd_v[rv32_pkg::WB_ALU]   = 5'd5;
    data_v[rv32_pkg::WB_ALU] = 32'hDEADBEEF;
    req_valid = 3'b001;
    cycle(g);
    drop_granted(g);
    cycle(g);
    cycle(g);

    // Reset arriving while a write is registered
    rd_v[rv32_pkg::WB_ALU]   = 5'd4;
    data_v[rv32_pkg::WB_ALU] = 32'h0000_4444;
    req_valid = 3'b001;
    cycle(g);
    drop_granted(g);
    check_eq("pre_async_we", 32'(rf_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rf_we", 32'(rf_we), 32'd0);
    check_eq("async_rf_rd", 32'(rf_rd), 32'd0);
    @(negedge clk);
    hold_reset();

    // Contention: all three valid continuously
    for (int i = 0; i < 3; i++) begin
      rd_v[i]   = 5'(i + 1);
      data_v[i] = 32'hA000_0000 + 32'(i);
    end
    req_valid = 3'b111;
    repeat (6) cycle(g);
    req_valid = 3'b000;
    cycle(g);

    // x0 write from LSU, plus an issue to x0
    rd_v[rv32_pkg::WB_LSU]   = 5'd0;
    data_v[rv32_pkg::WB_LSU] = 32'h1234;
    req_valid   = 3'b010;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    rs1         = 5'd0;
    cycle(g);
    drop_granted(g);
    issue_valid = 1'b0;
    cycle(g);
    cycle(g);

    // Scoreboard lifecycle for rd=7
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1         = 5'd7;
    cycle(g);
    issue_valid = 1'b0;
    cycle(g);
    cycle(g);
    rd_v[rv32_pkg::WB_MDU]   = 5'd7;
    data_v[rv32_pkg::WB_MDU] = 32'h0777_0777;
    req_valid = 3'b100;
    cycle(g);
    drop_granted(g);
    cycle(g);
    cycle(g);

    // Set/clear collision on rd=9
    rd_v[rv32_pkg::WB_ALU]   = 5'd9;
    data_v[rv32_pkg::WB_ALU] = 32'h9999_0000;
    req_valid = 3'b001;
    rs2       = 5'd9;
    cycle(g);
    drop_granted(g);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    cycle(g);
    issue_valid = 1'b0;
    cycle(g);
    check_eq("collision_pend", 32'(rs2_pending), 32'd1);
    cycle(g);

    // Random traffic; requesters keep rd/data stable until granted, issues avoid WAW
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          rd_v[i]      = 5'($urandom_range(31, 0));
          data_v[i]    = $urandom;
        end
      end
      issue_rd    = 5'($urandom_range(31, 0));
      issue_valid = ($urandom_range(2, 0) == 0) && !m_pend[issue_rd];
      rs1         = 5'($urandom_range(31, 0));
      rs2         = 5'($urandom_range(31, 0));
      cycle(g);
      drop_granted(g);
    end
    issue_valid = 1'b0;
    req_valid   = 3'b000;
    cycle(g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources: ALU, load unit and multiply/divide unit.
- Arbitration is round-robin over valid/ready handshakes. The winner is presented to the register file write port through one register stage.
- Holds a pending-write scoreboard: the issue stage marks a destination busy, and the committed write clears it.
- Decode queries the scoreboard for rs1/rs2 to generate RAW stalls.

Parameters:
NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MDU)
XLEN, 32, data width of writeback values

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a result to write
req_rd  in  NUM_REQ*5  destination register per requester, slice i = [5i+4:5i]
req_data  in  NUM_REQ*XLEN  result per requester, slice i = [XLEN*i+XLEN-1:XLEN*i]
req_ready  out  NUM_REQ  one-hot grant; requester i handshake completes when req_valid[i] && req_ready[i]
rf_we  out  1  register file write enable (registered)
rf_rd  out  5  register file destination (registered)
rf_data  out  XLEN  register file write data (registered)
issue_valid  in  1  instruction with a register destination is issuing this cycle
issue_rd  in  5  its destination register
rs1  in  5  decode source 1 query
rs2  in  5  decode source 2 query
rs1_pending  out  1  rs1 has an outstanding write (combinational)
rs2_pending  out  1  rs2 has an outstanding write (combinational)

Behaviour:
Reset (rst low, asynchronous):
- rf_we=0, rf_rd=0, rf_data=0.
- All pending bits cleared; round-robin pointer set to 0.
- req_ready is all zeros while rst is low.
- Reset mid-operation discards any registered write. rf_we is forced to 0 immediately, not at the next edge.

Arbitration:
- req_ready is combinational from req_valid and the pointer.
- Search starts at index ptr and goes upward with wrap-around. The first valid requester gets ready=1; all other ready bits are 0.
- At most one grant per cycle. With no valid requester, req_ready=0.
- req_ready never asserts for a requester with valid=0.
- On a grant to index g, ptr <= (g+1) mod NUM_REQ at the next edge. With no grant, ptr holds.
- The register file never back-pressures, so a valid requester waits at most NUM_REQ-1 cycles.
- Requesters hold req_rd/req_data stable while valid && !ready.

Write stage (latency 1):
- On a grant, the next edge loads rf_rd=req_rd[g] and rf_data=req_data[g].
- rf_we=1 iff req_rd[g]!=0. A granted rd=0 request is consumed, and rf_we stays 0, because x0 has no storage.
- Without a grant, rf_we <= 0 and rf_rd/rf_data hold their last value.

Scoreboard (32 bits, bit 0 hard-wired 0):
- Set pending[issue_rd] on an edge with issue_valid && issue_rd!=0.
- Clear pending[rf_rd] on an edge where rf_we=1. The register file absorbs the data on the same edge, so a source read in the following cycle sees the new value.
- Simultaneous set and clear of the same index: set wins.
- rsN_pending = pending[rsN]; the result is 0 for rsN=0.
- Issuing to a rd that is already pending (WAW) is illegal. Decode must stall on it. The bench asserts issue_valid -> !pending[issue_rd].

Decomposition:
- Shared package rv32_pkg holds XLEN, REG_ADDR_W=5, NUM_REGS=32, and requester index constants WB_ALU=0, WB_LSU=1, WB_MDU=2.
- Sub-module rr_arbiter (parameter N) holds the pointer register and one-hot grant logic; it can be reused for the memory-port arbiter.
- Scoreboard and write register live in wb_port_arbiter.

Test Plan:
- Reset then idle: rst low 2 cycles, release. Expect rf_we=0, all pending=0, req_ready=0. Assert rst low while rf_we=1 mid-run: rf_we drops to 0 without waiting for a clock edge.
- Single write: ALU valid, rd=5, data=32'hDEADBEEF. Expect ready[0]=1 in cycle 0; cycle 1 shows rf_we=1, rf_rd=5, rf_data=32'hDEADBEEF; cycle 2 shows rf_we=0.
- Contention fairness: all three valid continuously with rd=1/2/3. Grants follow 0,1,2,0,1,2. The rf_rd sequence is 1,2,3,1,2,3, one cycle delayed.
- x0 write: LSU valid rd=0 data=32'h1234. Expect ready[1]=1 and rf_we stays 0. Also drive issue_valid with issue_rd=0: rs1=0 gives rs1_pending=0.
- Scoreboard lifecycle: issue rd=7. Next cycle rs1=7 gives rs1_pending=1. MDU writes rd=7 three cycles later; rs1_pending=1 through the rf_we=1 cycle and =0 the cycle after.
- Set/clear collision: rf_we=1 with rf_rd=9 on the same edge as issue_valid with issue_rd=9. Expect rs2=9 gives rs2_pending=1 afterwards.
